// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: RV32 funct3 size codes,
// responder FSM states and the illegal-funct3 decode.
package data_mem_responder_pkg;

  localparam int unsigned Width = 32;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_e;

  // Unsigned variants only exist for loads, so a store with funct3[2] set is illegal.
  function automatic logic funct3_illegal(input logic [2:0] funct3, input logic we);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: write mask and replicated store data,
// load lane extraction with sign/zero extension, and misalignment detection.
module data_mem_responder_mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] rdword_i,
  output logic [3:0]       byte_mask_o,
  output logic [Width-1:0] wdata_shifted_o,
  output logic [Width-1:0] rdata_ext_o,
  output logic             misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdword_i >> {addr_lo_i, 3'b000});
  assign half_sel = 16'(rdword_i >> {addr_lo_i[1], 4'b0000});

  always_comb begin
    byte_mask_o     = 4'b0000;
    wdata_shifted_o = '0;
    rdata_ext_o     = '0;
    misaligned_o    = 1'b0;
    case (funct3_i)
      F3Byte, F3ByteU: begin
        // Replicating the store data lets the mask alone pick the destination lane.
        byte_mask_o     = 4'b0001 << addr_lo_i;
        wdata_shifted_o = {4{wdata_i[7:0]}};
        rdata_ext_o     = {{24{(funct3_i == F3Byte) & byte_sel[7]}}, byte_sel};
      end
      F3Half, F3HalfU: begin
        misaligned_o    = addr_lo_i[0];
        byte_mask_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_shifted_o = {2{wdata_i[15:0]}};
        rdata_ext_o     = {{16{(funct3_i == F3Half) & half_sel[15]}}, half_sel};
      end
      F3Word: begin
        misaligned_o    = |addr_lo_i;
        byte_mask_o     = 4'b1111;
        wdata_shifted_o = wdata_i;
        rdata_ext_o     = rdword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: one request in flight, fixed
// programmable accept-to-response latency, RV32 byte/half/word access with error flagging.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned Depth   = 1024,
  parameter int unsigned Latency = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [Width-1:0] req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [2:0]       req_funct3_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o
);

  localparam int unsigned IdxW    = $clog2(Depth);
  localparam logic [3:0]  CntLoad = 4'(Latency - 1);
  localparam bit          Direct  = (Latency == 1);

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic             we_q;
  logic [IdxW+1:0]  addr_q;
  logic [Width-1:0] wdata_q;
  logic [2:0]       funct3_q;

  logic [Width-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic latch_en, access_en, mem_we;

  logic             acc_we;
  logic [IdxW+1:0]  acc_addr;
  logic [Width-1:0] acc_wdata;
  logic [2:0]       acc_funct3;
  logic [IdxW-1:0]  acc_idx;
  logic             acc_err;

  logic [3:0]       byte_mask;
  logic [Width-1:0] wdata_shifted, rdata_ext, rdword;
  logic             misaligned;

  logic [Width-1:0] mem_q [Depth];

  // Address bits above the word index are ignored so accesses wrap modulo the array size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[Width-1:IdxW+2];

  // With Latency == 1 the access happens on the accept edge, before the latch holds the request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we     = req_we_i;
      acc_addr   = req_addr_i[IdxW+1:0];
      acc_wdata  = req_wdata_i;
      acc_funct3 = req_funct3_i;
    end else begin
      acc_we     = we_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      acc_funct3 = funct3_q;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];
  assign rdword  = mem_q[acc_idx];

  data_mem_responder_mem_lane_align u_lane_align (
    .funct3_i        (acc_funct3),
    .addr_lo_i       (acc_addr[1:0]),
    .wdata_i         (acc_wdata),
    .rdword_i        (rdword),
    .byte_mask_o     (byte_mask),
    .wdata_shifted_o (wdata_shifted),
    .rdata_ext_o     (rdata_ext),
    .misaligned_o    (misaligned)
  );

  assign acc_err = misaligned | funct3_illegal(acc_funct3, acc_we);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    latch_en    = 1'b0;
    access_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          latch_en = 1'b1;
          cnt_d    = CntLoad;
          if (Direct) begin
            state_d   = StResp;
            access_en = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StResp;
          access_en = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access_en) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? '0 : rdata_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch_en) begin
        we_q     <= req_we_i;
        addr_q   <= req_addr_i[IdxW+1:0];
        wdata_q  <= req_wdata_i;
        funct3_q <= req_funct3_i;
      end
    end
  end

  // The FSM sits in StIdle while reset is held, so block a Direct-mode write during reset.
  assign mem_we = access_en & acc_we & ~acc_err & rst_ni;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_mask[i]) begin
          mem_q[acc_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (Latency 2 and 1) checked every cycle against
// a timestamp/array reference model, plus directed transactions with literal expectations.
module tb_data_mem_responder;

  localparam int Depth = 1024;
  localparam int Lat[2] = '{2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_we = '0;
  logic [1:0][31:0]  req_addr = '0;
  logic [1:0][31:0]  req_wdata = '0;
  logic [1:0][2:0]   req_funct3 = '0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = '0;
  logic [1:0][31:0]  rsp_rdata;
  logic [1:0]        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.Depth(Depth), .Latency(2)) u_dut0 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[0]),
    .req_ready_o  (req_ready[0]),
    .req_we_i     (req_we[0]),
    .req_addr_i   (req_addr[0]),
    .req_wdata_i  (req_wdata[0]),
    .req_funct3_i (req_funct3[0]),
    .rsp_valid_o  (rsp_valid[0]),
    .rsp_ready_i  (rsp_ready[0]),
    .rsp_rdata_o  (rsp_rdata[0]),
    .rsp_err_o    (rsp_err[0])
  );

  data_mem_responder #(.Depth(Depth), .Latency(1)) u_dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[1]),
    .req_ready_o  (req_ready[1]),
    .req_we_i     (req_we[1]),
    .req_addr_i   (req_addr[1]),
    .req_wdata_i  (req_wdata[1]),
    .req_funct3_i (req_funct3[1]),
    .rsp_valid_o  (rsp_valid[1]),
    .rsp_ready_i  (rsp_ready[1]),
    .rsp_rdata_o  (rsp_rdata[1]),
    .rsp_err_o    (rsp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference semantics of one access: size/offset rules applied byte by byte.
  function automatic void ref_access(input logic [31:0] word, input bit we,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, output bit err,
                                     output logic [31:0] rdata, output logic [31:0] nword);
    int size;
    int off;
    bit uns;
    nword = word;
    rdata = 32'h0;
    err   = 1'b0;
    size  = 4;
    uns   = 1'b0;
    off   = int'(addr[1:0]);
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1'b1; end
      3'd5: begin size = 2; uns = 1'b1; end
      default: err = 1'b1;
    endcase
    if (we && uns) err = 1'b1;
    if (off % size != 0) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int b = 0; b < size; b++) nword[8*(off+b) +: 8] = wdata[8*b +: 8];
    end else begin
      for (int b = 0; b < size; b++) rdata[8*b +: 8] = word[8*(off+b) +: 8];
      if (!uns && rdata[8*size-1]) begin
        for (int b = size; b < 4; b++) rdata[8*b +: 8] = 8'hFF;
      end
    end
  endfunction

  // Model: a response becomes visible Lat cycles after the accept cycle and is held until taken.
  bit          m_busy[2] = '{0, 0};
  bit          m_valid[2] = '{0, 0};
  int          m_acc[2];
  bit          m_we[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic [2:0]  m_f3[2];
  bit          m_err[2];
  logic [31:0] m_rdata[2];
  logic [31:0] m_mem[2][Depth];
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    bit          e;
    logic [31:0] r;
    logic [31:0] w;
    int          idx;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d]  = 1'b0;
        m_valid[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d] && rsp_ready[d]) begin
          m_valid[d] = 1'b0;
          m_busy[d]  = 1'b0;
        end else if (!m_busy[d] && req_valid[d]) begin
          m_busy[d]  = 1'b1;
          m_acc[d]   = cyc;
          m_we[d]    = req_we[d];
          m_addr[d]  = req_addr[d];
          m_wdata[d] = req_wdata[d];
          m_f3[d]    = req_funct3[d];
        end
        if (m_busy[d] && !m_valid[d] && (cyc + 1 >= m_acc[d] + Lat[d])) begin
          idx = int'(m_addr[d] / 4) % Depth;
          ref_access(m_mem[d][idx], m_we[d], m_addr[d], m_wdata[d], m_f3[d], e, r, w);
          m_mem[d][idx] = w;
          m_valid[d]    = 1'b1;
          m_err[d]      = e;
          m_rdata[d]    = m_we[d] ? 32'h0 : r;
        end
      end
      cyc++;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_req_ready", d), 32'(req_ready[d]), 32'(!m_busy[d]));
      check($sformatf("dut%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'(m_valid[d]));
      if (m_valid[d]) begin
        check($sformatf("dut%0d_rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
        check($sformatf("dut%0d_rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
      end
    end
  end

  task automatic do_req(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rdata, output bit err, output int lat);
    int t;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_funct3[d] = f3;
    rsp_ready[d]  = 1'b1;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (t >= 50 || lat >= 50) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_handshake_timeout: accept wait %0d, response wait %0d, limit 50",
               d, t, lat);
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic expect_req(input string name, input int d, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [31:0] exp_rdata,
                            input bit exp_err, input int exp_lat);
    logic [31:0] rd;
    bit          er;
    int          lat;
    do_req(d, we, addr, wdata, f3, rd, er, lat);
    check({name, "_rdata"}, rd, exp_rdata);
    check({name, "_err"}, 32'(er), 32'(exp_err));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  int t;
  int nvalid;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset_rsp_rdata%0d", d), rsp_rdata[d], 32'h0);
      check($sformatf("reset_rsp_err%0d", d), 32'(rsp_err[d]), 32'd0);
    end
    rst_n = 1'b1;

    expect_req("sw_10",      0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 2);
    expect_req("lw_10",      0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 2);
    expect_req("sb_11",      0, 1'b1, 32'h11, 32'h00000080, 3'b000, 32'h0,        1'b0, 2);
    expect_req("lb_11",      0, 1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 2);
    expect_req("lbu_11",     0, 1'b0, 32'h11, 32'h0,        3'b100, 32'h00000080, 1'b0, 2);
    expect_req("lw_after_sb", 0, 1'b0, 32'h10, 32'h0,       3'b010, 32'hDEAD80EF, 1'b0, 2);
    expect_req("sh_13_mis",  0, 1'b1, 32'h13, 32'h00001234, 3'b001, 32'h0,        1'b1, 2);
    expect_req("lw_after_sh", 0, 1'b0, 32'h10, 32'h0,       3'b010, 32'hDEAD80EF, 1'b0, 2);
    expect_req("lh_12",      0, 1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 2);
    expect_req("lhu_12",     0, 1'b0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 1'b0, 2);
    expect_req("ld_f3_011",  0, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0,        1'b1, 2);
    expect_req("st_f3_100",  0, 1'b1, 32'h10, 32'h000000AA, 3'b100, 32'h0,        1'b1, 2);
    expect_req("sw_12_mis",  0, 1'b1, 32'h12, 32'h55555555, 3'b010, 32'h0,        1'b1, 2);
    expect_req("lw_after_err", 0, 1'b0, 32'h10, 32'h0,      3'b010, 32'hDEAD80EF, 1'b0, 2);

    // Backpressure: response held, and a competing store is refused.
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h10;
    req_funct3[0] = 3'b010;
    rsp_ready[0]  = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    t = 1;
    while (!rsp_valid[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_latency", 32'(t), 32'd2);
    for (int i = 0; i < 5; i++) begin
      req_valid[0]  = 1'b1;
      req_we[0]     = 1'b1;
      req_addr[0]   = 32'h10;
      req_wdata[0]  = 32'h0BAD0BAD;
      req_funct3[0] = 3'b010;
      check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rsp_rdata", rsp_rdata[0], 32'hDEAD80EF);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("bp_released", 32'(rsp_valid[0]), 32'd0);
    expect_req("lw_after_bp", 0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 2);

    // Latency 1 instance: aliasing and back-to-back throughput.
    expect_req("l1_sw_10",   1, 1'b1, 32'h10,   32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 1);
    expect_req("l1_lw_1010", 1, 1'b0, 32'h1010, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 1);
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_addr[1]   = 32'h1010;
    req_funct3[1] = 3'b010;
    rsp_ready[1]  = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) nvalid++;
    end
    req_valid[1] = 1'b0;
    check("l1_throughput", 32'(nvalid), 32'd5);
    repeat (2) @(negedge clk);
    rsp_ready[1] = 1'b0;

    // Reset during the wait of a store must drop the store.
    expect_req("sw_20",      0, 1'b1, 32'h20, 32'h11111111, 3'b010, 32'h0, 1'b0, 2);
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b1;
    req_addr[0]   = 32'h20;
    req_wdata[0]  = 32'h22222222;
    req_funct3[0] = 3'b010;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_req("lw_20_old",  0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h11111111, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
